// File: rtl/mux16_rr_sched_pkg.sv
// Shared types and helpers for the 16-way round-robin word scheduler.
// Holds the FSM encoding, requester/select sizing and the flattened-bus slice helper.
package mux16_rr_sched_pkg;

  localparam int NREQ  = 16;
  localparam int SEL_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Low bit position of entry idx inside a flattened bus of width-bit entries.
  function automatic int unsigned slice_lo(input logic [SEL_W-1:0] idx, input int unsigned width);
    return 32'(idx) * width;
  endfunction

endpackage

// File: rtl/mux16_rr_sched_rr_pick16.sv
// Combinational 16-bit rotate-priority picker: first set request at or above ptr,
// searching upward and wrapping 15 -> 0.
module rr_pick16
  import mux16_rr_sched_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [NREQ-1:0]  rot;
  logic [SEL_W-1:0] off;

  // Rotate so ptr lands on bit 0, take the lowest set bit, then rotate the offset back.
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    idx = ptr + off;
    any = |req;
  end

endmodule

// File: rtl/mux16_rr_sched.sv
// Packet-wise round-robin scheduler sharing one word datapath among 16 requesters.
// Optional statistics counters enabled by defining MUX16_RR_SCHED_STATS_EN.
module mux16_rr_sched
  import mux16_rr_sched_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int NREQ   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        in_valid,
  input  logic [NREQ-1:0]        in_last,
  input  logic [NREQ*DWIDTH-1:0] in_data,
  output logic [NREQ-1:0]        in_ready,
  output logic [SEL_W-1:0]       sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DWIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]       out_src,
  output logic                   out_last
`ifdef MUX16_RR_SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0]     pkt_cnt,
  output logic [31:0]            stall_cnt
`endif
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               out_valid_q, out_valid_d;
  logic [DWIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_src_q, out_src_d;
  logic               out_last_q, out_last_d;

  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DWIDTH-1:0]  sel_word;
  logic               can_load;
  logic               accept;
  logic               accept_last;

  rr_pick16 u_pick (
    .req (in_valid),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // 16:1 word mux steered by the held grant.
  always_comb begin
    sel_word = in_data[slice_lo(sel_q, DWIDTH) +: DWIDTH];
  end

  // Handshake: the granted source may push whenever the output register is empty or draining.
  always_comb begin
    can_load    = ~out_valid_q | out_ready;
    in_ready    = '0;
    accept      = 1'b0;
    if (state_q == ST_GRANT) begin
      in_ready[sel_q] = can_load;
      accept          = in_valid[sel_q] & can_load;
    end
    accept_last = accept & in_last[sel_q];
  end

  // Arbitration FSM: IDLE picks a winner, GRANT holds it until its last beat is taken.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (accept_last) begin
          ptr_d   = sel_q + SEL_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register: load on accept, drop valid once drained with nothing new behind it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_word;
      out_src_d   = sel_q;
      out_last_d  = in_last[sel_q];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
    end
  end

  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;

`ifdef MUX16_RR_SCHED_STATS_EN
  logic [NREQ*16-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0]        stall_cnt_q, stall_cnt_d;

  // Per-source packet counters wrap; the stall counter saturates.
  always_comb begin
    pkt_cnt_d   = pkt_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (accept_last) begin
      pkt_cnt_d[slice_lo(sel_q, 16) +: 16] = pkt_cnt_q[slice_lo(sel_q, 16) +: 16] + 16'd1;
    end
    if (out_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/mux16_rr_sched.md
Name: mux16_rr_sched

Overview:
- Round-robin scheduler that shares one 32-bit datapath between 16 requesters (e.g. feature/pixel-word sources feeding the classifier stage).
- Arbitrates packet-wise: a grant is held until the granted source's last beat is accepted.
- Drives the 4-bit select of a 16:1 32-bit word mux and registers the selected word into a valid/ready output stage.

Parameters:
- DWIDTH, 32, data word width per requester
- NREQ, 16, number of requesters (fixed 16; select width 4)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  16  per-requester beat valid; a high bit is also that source's request
- in_last  input  16  per-requester last-beat-of-packet flag
- in_data  input  16*DWIDTH  flattened words; source i at [i*DWIDTH +: DWIDTH]
- in_ready  output  16  per-requester accept; at most one bit high
- sel  output  4  current grant index (mux select)
- out_valid  output  1  registered output beat valid
- out_ready  input  1  downstream accept
- out_data  output  DWIDTH  registered selected word
- out_src  output  4  source index of out_data
- out_last  output  1  last flag of out_data

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous, active-low.
- Reset values: state=IDLE, ptr=0, sel=0, in_ready=0, out_valid=0, out_data=0, out_src=0, out_last=0.
- States:
  - IDLE: if any in_valid, grant g = first index ≥ ptr with in_valid set, searching upward and wrapping 15→0. At the next edge, sel←g and state→GRANT. No beat is accepted in IDLE.
  - GRANT: in_ready[sel] = (~out_valid | out_ready); all other in_ready bits are 0.
- Beat accept (in_valid[sel] & in_ready[sel]):
  - Next edge loads out_data←in_data[sel], out_src←sel, out_last←in_last[sel], out_valid←1.
  - Latency: input accept to out_valid is 1 cycle.
  - If the accepted beat has in_last: ptr←(sel+1) mod 16, state→IDLE.
- Output stage:
  - Holds data while out_valid & ~out_ready.
  - Clears out_valid on out_ready with no new accept.
  - Accept and drain in the same cycle give full throughput: 1 beat/cycle within a packet.
- Packet gap: after a last beat, one IDLE cycle precedes the next grant (arbitration bubble).
- In GRANT, in_valid[sel] deasserting mid-packet stalls; the grant is held and other requesters wait. No timeout.
- Single-beat packet (in_last on first beat) is legal.
- Only one requester active: it is regranted after each packet, with one bubble cycle between packets.
- ptr wrap: ptr=15 with grant 15 finishing → ptr=0.
- Upstream must keep in_data/in_last stable while in_valid is high and not yet accepted.
- Reset mid-packet: everything returns to reset values next edge. The partial packet is dropped and out_valid is cleared.

Optional Feature:
- Macro: MUX16_RR_SCHED_STATS_EN
- With macro defined: adds ports pkt_cnt output 16*16 and stall_cnt output 32.
  - pkt_cnt[i*16 +: 16] increments on each accepted last beat from source i, wrapping.
  - stall_cnt increments each cycle with out_valid & ~out_ready, saturating at 2^32-1.
  - Both reset to 0.
- Without macro: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding constants (ST_IDLE=0, ST_GRANT=1)
  - NREQ=16, SEL_W=4
  - the index-slice helper for the flattened in_data.
- One natural sub-module, rr_pick16: combinational 16-bit rotate-priority picker.
  - Inputs: req[15:0], ptr[3:0]. Outputs: idx[3:0], any.
  - Reusable by other shared-resource schedulers.
- Word selection is done by a 16:1 DWIDTH mux instance driven by sel.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=16'hFFFF → in_ready=0, out_valid=0, sel=0. Release → grant 0 after 1 IDLE cycle.
- Round-robin: all 16 requesters issue 1-beat packets (data=32'hA000_0000+i), out_ready=1 → out_src sequence 0,1,…,15,0 with matching data; 2 cycles per packet.
- Packet hold: src 3 sends 4 beats (last on 4th) while src 4 requests → src 4 is not granted until after src 3's 4th beat. out_data is 4 beats of src 3 in order.
- Backpressure: during a src 5 packet, out_ready=0 for 5 cycles → out_data stable, in_ready[5]=0. stall_cnt=5 if STATS_EN. Release → next beat accepted, no loss or duplication.
- Wrap and skip: ptr=14, requests only on 2 and 9 → grant 2, then 9, then 2.
- Reset mid-packet: assert rst_n=0 on the 2nd of 4 beats → out_valid=0, ptr=0 next cycle. After release, lowest requesting index is granted first.
